// File: rtl/fila_requisicoes.sv
// fila_requisicoes: request queue for the elevator controller.
// Floor codes are captured on an enable/D strobe, kept in arrival order,
// and handed to the dispatcher one at a time over valid/ready. A code
// that is already pending is dropped instead of being stored twice.
module fila_requisicoes #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         D,
  input  logic                     ready,
  output logic [WIDTH-1:0]         Q,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dup,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rp;
  logic [AW-1:0]    r_wp;
  logic [CW-1:0]    r_count;
  logic             r_dup;
  logic             r_overflow;

  logic             w_valid;
  logic             w_pop;
  logic             w_dup_hit;
  logic             w_full_blk;
  logic             w_push;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && ready;
  // A full queue still takes a write when the head leaves on the same edge.
  assign w_full_blk = (r_count == C_DEPTH) && !w_pop;
  assign w_push     = enable && !w_dup_hit && !w_full_blk;

  // Compare D against every entry that is still pending after this edge's pop.
  always_comb begin
    w_dup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && !(w_pop && (i == 0)) &&
          (r_mem[r_rp + AW'(i)] == D))
        w_dup_hit = 1'b1;
    end
  end

  // Storage: write the accepted code at the write pointer; slots are not cleared on pop.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wp] <= D;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push) r_wp <= r_wp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drop indications: single-cycle pulses reporting why the last write was discarded.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_dup      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_dup      <= enable && w_dup_hit;
      r_overflow <= enable && !w_dup_hit && w_full_blk;
    end
  end

  // Outputs decode registered state only, so there is no input-to-output path.
  always_comb begin
    valid    = w_valid;
    Q        = w_valid ? r_mem[r_rp] : '0;
    count    = r_count;
    full     = (r_count == C_DEPTH);
    empty    = (r_count == '0);
    dup      = r_dup;
    overflow = r_overflow;
  end

endmodule

// File: tb/tb_fila_requisicoes.sv
// Bench for fila_requisicoes: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference of the request list.
module tb_fila_requisicoes;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock   = 1'b0;
  logic             clear_n = 1'b0;
  logic             enable  = 1'b0;
  logic [WIDTH-1:0] D       = '0;
  logic             ready   = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             dup;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int model[$];
  logic exp_dup = 1'b0;
  logic exp_ovf = 1'b0;
  int max_cnt;

  fila_requisicoes #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .clear_n(clear_n), .enable(enable), .D(D), .ready(ready),
    .Q(Q), .valid(valid), .full(full), .empty(empty), .count(count),
    .dup(dup), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = model.size();
    check({tag, ".Q"},        32'(Q),        (sz > 0) ? 32'(model[0]) : 32'd0);
    check({tag, ".valid"},    32'(valid),    32'(sz > 0));
    check({tag, ".count"},    32'(count),    32'(sz));
    check({tag, ".full"},     32'(full),     32'(sz == DEPTH));
    check({tag, ".empty"},    32'(empty),    32'(sz == 0));
    check({tag, ".dup"},      32'(dup),      32'(exp_dup));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  // One clock edge: apply inputs, advance the reference list, then compare.
  task automatic step(input string tag, input logic en, input int d, input logic rd);
    bit found;
    @(negedge clock);
    enable = en;
    D      = WIDTH'(d);
    ready  = rd;
    if (rd && model.size() > 0) void'(model.pop_front());
    exp_dup = 1'b0;
    exp_ovf = 1'b0;
    if (en) begin
      found = 1'b0;
      foreach (model[i]) if (model[i] == d) found = 1'b1;
      if (found)                      exp_dup = 1'b1;
      else if (model.size() == DEPTH) exp_ovf = 1'b1;
      else                            model.push_back(d);
    end
    @(posedge clock);
    #1;
    check_all(tag);
    enable = 1'b0;
    ready  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    clear_n = 1'b1;

    // Basic push then ordered pop
    step("push3", 1'b1, 3, 1'b0);
    step("push5", 1'b1, 5, 1'b0);
    step("push9", 1'b1, 9, 1'b0);
    check("tp1_count", 32'(count), 32'd3);
    check("tp1_head",  32'(Q),     32'd3);
    step("pop_a", 1'b0, 0, 1'b1);
    check("tp1_q5", 32'(Q), 32'd5);
    step("pop_b", 1'b0, 0, 1'b1);
    check("tp1_q9", 32'(Q), 32'd9);
    step("pop_c", 1'b0, 0, 1'b1);
    check("tp1_empty", 32'(empty), 32'd1);

    // Duplicate dropped; same code accepted when the head leaves that edge
    step("push7",    1'b1, 7, 1'b0);
    step("dup7",     1'b1, 7, 1'b0);
    check("tp2_dup", 32'(dup), 32'd1);
    step("idle",     1'b0, 0, 1'b0);
    step("push7pop", 1'b1, 7, 1'b1);
    check("tp2_nodup", 32'(dup), 32'd0);
    check("tp2_q7",    32'(Q),   32'd7);
    drain();

    // Overflow, then full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, i, 1'b0);
    step("ovf6", 1'b1, 6, 1'b0);
    check("tp3_ovf", 32'(overflow), 32'd1);
    step("full_pp", 1'b1, 6, 1'b1);
    check("tp3_q2",    32'(Q),     32'd2);
    check("tp3_count", 32'(count), 32'd4);
    drain();

    // Pointer wrap with push/pop pairs
    step("wrap0", 1'b1, 0, 1'b0);
    max_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      step("wrap", 1'b1, i, 1'b1);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    step("wrap_end", 1'b0, 0, 1'b1);
    check("tp4_maxcnt", 32'(max_cnt <= 2), 32'd1);
    drain();

    // Asynchronous reset between edges
    step("pre_a", 1'b1, 1, 1'b0);
    step("pre_b", 1'b1, 2, 1'b0);
    step("pre_c", 1'b1, 3, 1'b0);
    @(negedge clock);
    #2;
    clear_n = 1'b0;
    #1;
    model.delete();
    exp_dup = 1'b0;
    exp_ovf = 1'b0;
    check_all("async_rst");
    @(negedge clock);
    clear_n = 1'b1;
    step("post_rst8", 1'b1, 8, 1'b0);
    check("tp5_q8", 32'(Q), 32'd8);
    drain();

    // Empty with push and ready on the same edge
    step("empty_pp", 1'b1, 12, 1'b1);
    check("tp6_count", 32'(count), 32'd1);
    check("tp6_q12",   32'(Q),     32'd12);
    step("tp6_pop", 1'b0, 0, 1'b1);

    // Random traffic on a narrow code range to provoke duplicates and full
    for (int n = 0; n < 400; n++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
